// File: rtl/hazard_stall_ctrl.sv
// Decode-stage stall/flush control: Tuse/Tnew data hazards, mult/div busy
// sequencing, and a saturating stall-cycle counter for CPI measurement.
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [4:0]       RS_D,
  input  logic [4:0]       RT_D,
  input  logic [1:0]       TuseRS_D,
  input  logic [1:0]       TuseRT_D,
  input  logic             MDUse_D,
  input  logic [4:0]       WriteRd_E,
  input  logic             RegWrite_E,
  input  logic [1:0]       TnewE,
  input  logic [4:0]       WriteRd_M,
  input  logic             RegWrite_M,
  input  logic [1:0]       TnewM,
  input  logic             MDStart_E,
  input  logic             MDIsDiv_E,
  output logic             Stall,
  output logic             FlushE,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MW = $clog2(DIV_CYC + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [MW-1:0] DIV_LD = MW'(DIV_CYC - 1);
  localparam logic [MW-1:0] MUL_LD = MW'(MULT_CYC - 1);
  localparam logic [MW-1:0] MD_ONE = MW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]    state;
  logic [MW-1:0] md_cnt;
  logic          stall_rs;
  logic          stall_rt;
  logic          stall_md;
  logic          stall_any;

  // Stall while a producer's result arrives later than the consumer needs it
  always_comb begin
    stall_rs = (RS_D != 5'd0) &
      ((RegWrite_E & (WriteRd_E == RS_D) & (TuseRS_D < TnewE)) |
       (RegWrite_M & (WriteRd_M == RS_D) & (TuseRS_D < TnewM)));
    stall_rt = (RT_D != 5'd0) &
      ((RegWrite_E & (WriteRd_E == RT_D) & (TuseRT_D < TnewE)) |
       (RegWrite_M & (WriteRd_M == RT_D) & (TuseRT_D < TnewM)));
    stall_md  = MDUse_D & (md_busy | MDStart_E);
    stall_any = (stall_rs | stall_rt | stall_md) & ~Reset;
  end

  assign Stall   = stall_any;
  assign FlushE  = stall_any;
  assign md_busy = (state == BUSY);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MDStart_E) begin
            state  <= BUSY;
            md_cnt <= MDIsDiv_E ? DIV_LD : MUL_LD;
          end
        end
        BUSY: begin
          if (md_cnt != '0) md_cnt <= md_cnt - MD_ONE;
          else              state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset)
      stall_cnt <= '0;
    else if (stall_any && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares them against both DUT instances.
module tb_hazard_stall_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [4:0]  RS_D, RT_D, WriteRd_E, WriteRd_M;
  logic [1:0]  TuseRS_D, TuseRT_D, TnewE, TnewM;
  logic        MDUse_D, RegWrite_E, RegWrite_M, MDStart_E, MDIsDiv_E;
  logic        Stall, FlushE, md_busy;
  logic [31:0] stall_cnt;
  logic        Stall4, FlushE4, md_busy4;
  logic [3:0]  stall_cnt4;

  always #5 CLK = ~CLK;

  hazard_stall_ctrl dut (
    .CLK(CLK), .Reset(Reset), .RS_D(RS_D), .RT_D(RT_D),
    .TuseRS_D(TuseRS_D), .TuseRT_D(TuseRT_D), .MDUse_D(MDUse_D),
    .WriteRd_E(WriteRd_E), .RegWrite_E(RegWrite_E), .TnewE(TnewE),
    .WriteRd_M(WriteRd_M), .RegWrite_M(RegWrite_M), .TnewM(TnewM),
    .MDStart_E(MDStart_E), .MDIsDiv_E(MDIsDiv_E),
    .Stall(Stall), .FlushE(FlushE), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .Reset(Reset), .RS_D(RS_D), .RT_D(RT_D),
    .TuseRS_D(TuseRS_D), .TuseRT_D(TuseRT_D), .MDUse_D(MDUse_D),
    .WriteRd_E(WriteRd_E), .RegWrite_E(RegWrite_E), .TnewE(TnewE),
    .WriteRd_M(WriteRd_M), .RegWrite_M(RegWrite_M), .TnewM(TnewM),
    .MDStart_E(MDStart_E), .MDIsDiv_E(MDIsDiv_E),
    .Stall(Stall4), .FlushE(FlushE4), .md_busy(md_busy4),
    .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_cnt  = '0;
  logic [3:0]  m_cnt4 = '0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".Stall"},   32'(Stall),      32'(e.stall));
      chk({e.tag, ".FlushE"},  32'(FlushE),     32'(e.stall));
      chk({e.tag, ".md_busy"}, 32'(md_busy),    32'(e.busy));
      chk({e.tag, ".cnt"},     stall_cnt,       e.cnt);
      chk({e.tag, ".cnt4"},    32'(stall_cnt4), 32'(e.cnt4));
      chk({e.tag, ".Stall4"},  32'(Stall4),     32'(e.stall));
    end
  end

  // One clock cycle: queue the expectation for the current inputs, then
  // advance the stall-counter model to the next cycle.
  task automatic cyc(input logic s, input logic b, input string tag);
    exp_t e;
    e.stall = s;
    e.busy  = b;
    e.cnt   = m_cnt;
    e.cnt4  = m_cnt4;
    e.tag   = tag;
    sb.push_back(e);
    if (Reset) begin
      m_cnt  = '0;
      m_cnt4 = '0;
    end else if (s) begin
      m_cnt = m_cnt + 32'd1;
      if (m_cnt4 != 4'hf) m_cnt4 = m_cnt4 + 4'd1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    RS_D = 5'd0; RT_D = 5'd0; TuseRS_D = 2'd3; TuseRT_D = 2'd3;
    MDUse_D = 1'b0; WriteRd_E = 5'd0; RegWrite_E = 1'b0; TnewE = 2'd0;
    WriteRd_M = 5'd0; RegWrite_M = 1'b0; TnewM = 2'd0;
    MDStart_E = 1'b0; MDIsDiv_E = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, want finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    cyc(1'b0, 1'b0, "reset");
    Reset = 1'b0;

    RegWrite_E = 1'b1; WriteRd_E = 5'd8; TnewE = 2'd2;
    RS_D = 5'd8; TuseRS_D = 2'd0;
    cyc(1'b1, 1'b0, "e_rs_tuse0");
    TuseRS_D = 2'd1; cyc(1'b1, 1'b0, "e_rs_tuse1");
    TuseRS_D = 2'd2; cyc(1'b0, 1'b0, "e_rs_tuse2");
    TuseRS_D = 2'd3; cyc(1'b0, 1'b0, "e_rs_tuse3");
    WriteRd_E = 5'd0; RS_D = 5'd0; TuseRS_D = 2'd0;
    cyc(1'b0, 1'b0, "reg0");
    WriteRd_E = 5'd8; RS_D = 5'd8; RegWrite_E = 1'b0;
    cyc(1'b0, 1'b0, "no_regwrite");

    idle_inputs();
    RegWrite_M = 1'b1; WriteRd_M = 5'd9; TnewM = 2'd1;
    RT_D = 5'd9; TuseRT_D = 2'd0;
    cyc(1'b1, 1'b0, "m_rt_tnew1");
    TnewM = 2'd0; cyc(1'b0, 1'b0, "m_rt_tnew0");

    TnewM = 2'd1;
    RegWrite_E = 1'b1; WriteRd_E = 5'd8; TnewE = 2'd1;
    RS_D = 5'd8; TuseRS_D = 2'd0;
    cyc(1'b1, 1'b0, "both");

    idle_inputs();
    MDStart_E = 1'b1; MDIsDiv_E = 1'b1; MDUse_D = 1'b1;
    cyc(1'b1, 1'b0, "div_start");
    MDStart_E = 1'b0; MDIsDiv_E = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, "div_busy");
    cyc(1'b0, 1'b0, "div_done");

    MDStart_E = 1'b1;
    cyc(1'b1, 1'b0, "mult_start");
    MDStart_E = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, "mult_busy");
    cyc(1'b0, 1'b0, "mult_done");

    MDUse_D = 1'b0; MDStart_E = 1'b1; MDIsDiv_E = 1'b1;
    cyc(1'b0, 1'b0, "div2_start");
    MDStart_E = 1'b0;
    cyc(1'b0, 1'b1, "div2_busy1");
    cyc(1'b0, 1'b1, "div2_busy2");
    Reset = 1'b1; MDUse_D = 1'b1;
    cyc(1'b0, 1'b1, "rst_mid_busy");
    Reset = 1'b0;
    cyc(1'b0, 1'b0, "after_rst");

    Reset = 1'b1; MDStart_E = 1'b1;
    cyc(1'b0, 1'b0, "rst_vs_start");
    Reset = 1'b0; MDStart_E = 1'b0;
    cyc(1'b0, 1'b0, "rst_won");

    idle_inputs();
    RegWrite_E = 1'b1; WriteRd_E = 5'd5; TnewE = 2'd2;
    RS_D = 5'd5; TuseRS_D = 2'd0;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, "sat");
    idle_inputs();
    cyc(1'b0, 1'b0, "end");

    repeat (2) @(posedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
